// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the write-back slice.
//   result_src_e : write-back result select (ALU / LOAD / PC4; 2'b11 reads as ALU)
//   F3_*         : funct3 load size/sign encodings
package rv32_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load extension: selects the byte/halfword lane of an aligned memory word
// and sign- or zero-extends it according to funct3.
//   funct3_i : load size/sign
//   addr_i   : low address bits (byte lane; bit 1 selects halfword)
//   rdata_i  : raw aligned data word
//   value_o  : extended load value (full word for lw and unknown encodings)
module load_ext
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    unique case (addr_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    value_o = rdata_i;
    case (funct3_i)
      F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value_o = {24'd0, byte_sel};
      F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value_o = {16'd0, half_sel};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32 write-back stage: a single-entry buffer between MEM and the register
// file. An accepted instruction is written (we3/a3/wd3) in the following
// cycle; wb_hold freezes the entry, wb_flush drops the current offer.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   mem_valid / mem_ready      : MEM offer handshake
//   mem_reg_write, mem_rd,
//   mem_result_src, mem_funct3,
//   mem_alu_result, mem_rdata,
//   mem_pc_plus4               : offered instruction fields
//   wb_hold, wb_flush          : stall held entry / kill offer
//   we3, a3, wd3               : register-file write port
//   instret                    : retired count (only with RV32_WB_INSTRET_EN)
// Build option: define RV32_WB_INSTRET_EN to add the instret counter/port.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_result_src,
  input  logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_alu_result,
  input  logic [31:0]          mem_rdata,
  input  logic [31:0]          mem_pc_plus4,
  input  logic                 wb_hold,
  input  logic                 wb_flush,
  output logic                 we3,
  output logic [4:0]           a3,
  output logic [31:0]          wd3
`ifdef RV32_WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  logic        wb_valid_q;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [1:0]  result_src_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_result_q;
  logic [31:0] rdata_q;
  logic [31:0] pc_plus4_q;

  logic        capture;
  logic        retire;
  logic [31:0] load_value;

  assign mem_ready = !wb_valid_q || !wb_hold;
  assign capture   = mem_valid && mem_ready && !wb_flush;
  assign retire    = wb_valid_q && !wb_hold;

  // A capture in the retire cycle overwrites the entry, so valid stays set
  // and throughput is one instruction per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      rdata_q      <= '0;
      pc_plus4_q   <= '0;
    end else if (capture) begin
      wb_valid_q   <= 1'b1;
      reg_write_q  <= mem_reg_write;
      rd_q         <= mem_rd;
      result_src_q <= mem_result_src;
      funct3_q     <= mem_funct3;
      alu_result_q <= mem_alu_result;
      rdata_q      <= mem_rdata;
      pc_plus4_q   <= mem_pc_plus4;
    end else if (retire) begin
      wb_valid_q   <= 1'b0;
    end
  end

  load_ext u_load_ext (
    .funct3_i (funct3_q),
    .addr_i   (alu_result_q[1:0]),
    .rdata_i  (rdata_q),
    .value_o  (load_value)
  );

  assign we3 = retire && reg_write_q && (rd_q != 5'd0);
  assign a3  = rd_q;

  always_comb begin
    wd3 = alu_result_q;
    case (result_src_q)
      RS_LOAD: wd3 = load_value;
      RS_PC4:  wd3 = pc_plus4_q;
      default: wd3 = alu_result_q;
    endcase
  end

`ifdef RV32_WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mem_valid, input, 1: the MEM stage offers an instruction this cycle.
REQ-005 SHALL have port mem_ready, output, 1: wb_stage accepts the offered instruction this cycle.
REQ-006 SHALL have port mem_reg_write, input, 1: the instruction writes rd.
REQ-007 SHALL have port mem_rd, input, 5: destination register index.
REQ-008 SHALL have port mem_result_src, input, 2: result select (ALU, LOAD, PC4; encoding 11 is treated as ALU).
REQ-009 SHALL have port mem_funct3, input, 3: load size and sign.
REQ-010 SHALL have port mem_alu_result, input, 32: ALU result or load address.
REQ-011 SHALL have port mem_rdata, input, 32: raw aligned data word from memory.
REQ-012 SHALL have port mem_pc_plus4, input, 32: link value for jal/jalr.
REQ-013 SHALL have port wb_hold, input, 1: hold the held entry; no retire, no accept.
REQ-014 SHALL have port wb_flush, input, 1: kill the offered instruction.
REQ-015 SHALL have port we3, output, 1: register-file write enable.
REQ-016 SHALL have port a3, output, 5: register-file write address.
REQ-017 SHALL have port wd3, output, 32: register-file write data.

Function
REQ-018 SHALL hold one entry (wb_valid plus captured fields); mem_ready = !wb_valid || !wb_hold.
REQ-019 SHALL capture fields and set wb_valid at a rising edge where mem_valid && mem_ready && !wb_flush.
REQ-020 SHALL clear wb_valid at a rising edge where the entry retires and nothing is captured; a simultaneous capture SHALL overwrite the entry (back-to-back throughput of 1 per cycle).
REQ-021 SHALL give wb_flush priority over mem_valid; a flushed offer SHALL be dropped without affecting the held entry.
REQ-022 SHALL retire the entry in a cycle where wb_valid && !wb_hold.
REQ-023 SHALL drive we3 = wb_valid && !wb_hold && wb_reg_write && (wb_rd != 0); a3 = wb_rd; we3 SHALL never assert for x0.
REQ-024 SHALL compute wd3 combinationally from registered fields: ALU gives alu_result, PC4 gives pc_plus4, LOAD gives the extended load value.
REQ-025 SHALL implement load extension as follows: byte lane = alu_result[1:0] and halfword = alu_result[1]; 000 lb sign-extends; 100 lbu zero-extends; 001 lh sign-extends; 101 lhu zero-extends; 010 and others give the full word.
REQ-026 SHALL make the latency from acceptance to we3 exactly one cycle; the register file captures on the falling edge inside that retire cycle.
REQ-027 SHALL keep we3, a3 and wd3 stable while wb_hold is asserted, with we3 low.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear wb_valid, all captured fields and the counter; we3=0, a3=0, wd3=0, mem_ready=1.
REQ-029 SHALL, on reset asserted mid-operation, discard the held entry; no write SHALL occur after reset assertion.
REQ-030 SHALL resume accepting on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when macro RV32_WB_INSTRET_EN is defined, add output port instret, width INSTRET_W, which increments by 1 at each rising edge following a retire (including retires with no register write) and wraps to 0 at all-ones.
REQ-032 SHALL, without RV32_WB_INSTRET_EN, omit the instret port and counter entirely, with all other behaviour identical.

Structure
REQ-033 SHALL place result_src_e (ALU=00, LOAD=01, PC4=10) and the funct3 load-encoding constants in shared package rv32_pkg.
REQ-034 SHALL implement load extension as sub-module load_ext (combinational: funct3, addr[1:0], rdata -> value).

Verification
REQ-035 SHALL cover: LOAD lb with addr[1:0]=3 and rdata=0x80_00_00_00, rd=5 -> one cycle later we3=1, a3=5, wd3=0xFFFFFF80.
REQ-036 SHALL cover: LOAD lhu with addr[1:0]=2 and rdata=0xBEEF_1234 -> wd3=0x0000BEEF; lh with the same inputs -> wd3=0xFFFFBEEF.
REQ-037 SHALL cover: ALU with rd=0 and alu_result=0x1234 -> we3=0; with RV32_WB_INSTRET_EN defined, instret still increments by 1.
REQ-038 SHALL cover: wb_hold asserted 3 cycles with an entry held -> mem_ready=0 and we3=0 for 3 cycles, then a single write with no duplicate retire.
REQ-039 SHALL cover: mem_valid and wb_flush both asserted -> no capture, and we3 stays 0 in the next cycle.
REQ-040 SHALL cover: rst_n dropped while wb_valid=1 -> we3 falls immediately (asynchronously) and instret=0.
